delivery_dispatch_ctrl: RTL and testbench



---
 rtl/delivery_pkg.sv | 26 ++
 rtl/delivery_rr_arbiter.sv | 33 +++
 rtl/delivery_dispatch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_delivery_dispatch_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/delivery_pkg.sv
// Shared types for the delivery truck dispatcher: controller states, delivery
// outcome and the supported requester ceiling.
package delivery_pkg;

    localparam int NUM_REQ_MAX = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CUSTOMS,
        S_LOAD,
        S_TRANSIT,
        S_DONE,
        S_FAIL
    } dlv_state_e;

    typedef enum logic {
        DLV_OK,
        DLV_FAIL
    } dlv_outcome_e;

    // Terminal state reached once a shipment has resolved one way or the other.
    function automatic dlv_state_e outcome_state(input dlv_outcome_e outcome);
        return (outcome == DLV_OK) ? S_DONE : S_FAIL;
    endfunction

endpackage

// File: rtl/delivery_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after last_grant,
// wrapping modulo NUM_REQ. The controller registers the result.
module delivery_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output and temporary gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        // Offset 1 first, so the previous owner is considered last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                grant_idx = cand;
                grant     = NUM_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/delivery_dispatch_ctrl.sv
// Round-robin owner of the shared delivery truck; walks each shipment through
// customs, loading and transit. Define DELIVERY_TIMEOUT_EN for a per-wait-state abort.
module delivery_dispatch_ctrl
    import delivery_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       customs_cleared,
    input  logic                       transit_ready,
    input  logic                       arrived_on_truck,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       delivery_confirmed,
    output logic                       delivery_failed,
    output logic [$clog2(NUM_REQ)-1:0] done_id
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX || WAIT_LIMIT < 1) begin : g_cfg_check
        $error("delivery_dispatch_ctrl: NUM_REQ or WAIT_LIMIT out of range");
    end

    dlv_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   done_id_q, done_id_d;
    logic               busy_q, busy_d;
    logic               confirmed_q, confirmed_d;
    logic               failed_q, failed_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               owner_req;
    logic               in_wait;
    logic               timeout;
    dlv_outcome_e       arrival_outcome;

    delivery_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arbiter (
        .req       (req),
        .last_grant(last_grant_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign owner_req       = |(req & grant_q);
    assign in_wait         = state_q inside {S_CUSTOMS, S_LOAD, S_TRANSIT};
    assign arrival_outcome = (customs_cleared && transit_ready) ? DLV_OK : DLV_FAIL;

`ifdef DELIVERY_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    assign timeout = (wait_cnt_q == CNT_W'(WAIT_LIMIT));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;

        // Owner abort outranks progress; progress outranks timeout.
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    state_d      = S_CUSTOMS;
                    grant_d      = arb_grant;
                    grant_id_d   = arb_idx;
                    last_grant_d = arb_idx;
                end
            end
            S_CUSTOMS: begin
                if (!owner_req)           state_d = S_FAIL;
                else if (customs_cleared) state_d = S_LOAD;
                else if (timeout)         state_d = S_FAIL;
            end
            S_LOAD: begin
                if (!owner_req)                             state_d = S_FAIL;
                else if (transit_ready && customs_cleared)  state_d = S_TRANSIT;
                else if (timeout)                           state_d = S_FAIL;
            end
            S_TRANSIT: begin
                if (!owner_req)            state_d = S_FAIL;
                else if (arrived_on_truck) state_d = outcome_state(arrival_outcome);
                else if (timeout)          state_d = S_FAIL;
            end
            S_DONE, S_FAIL: begin
                state_d    = S_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
            end
            default: begin
                state_d    = S_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        busy_d      = (state_d != S_IDLE);
        confirmed_d = (state_d == S_DONE);
        failed_d    = (state_d == S_FAIL);
        done_id_d   = (confirmed_d || failed_d) ? grant_id_q : '0;

`ifdef DELIVERY_TIMEOUT_EN
        if (!in_wait || state_d != state_q) wait_cnt_d = '0;
        else if (timeout)                   wait_cnt_d = wait_cnt_q;
        else                                wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            grant_id_q   <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            done_id_q    <= '0;
            busy_q       <= 1'b0;
            confirmed_q  <= 1'b0;
            failed_q     <= 1'b0;
`ifdef DELIVERY_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            done_id_q    <= done_id_d;
            busy_q       <= busy_d;
            confirmed_q  <= confirmed_d;
            failed_q     <= failed_d;
`ifdef DELIVERY_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign grant              = grant_q;
    assign grant_id           = grant_id_q;
    assign busy               = busy_q;
    assign delivery_confirmed = confirmed_q;
    assign delivery_failed    = failed_q;
    assign done_id            = done_id_q;

endmodule

// File: tb/tb_delivery_dispatch_ctrl.sv
// Bench for delivery_dispatch_ctrl: a shipment-level model checked every cycle
// plus directed scenarios with literal expectations. Honours DELIVERY_TIMEOUT_EN.
module tb_delivery_dispatch_ctrl;

    localparam int NUM_REQ    = 4;
    localparam int WAIT_LIMIT = 15;
`ifdef DELIVERY_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_REQ-1:0] req = '0;
    logic               customs = 1'b0;
    logic               transit = 1'b0;
    logic               arrived = 1'b0;
    logic [NUM_REQ-1:0] grant;
    logic [1:0]         grant_id;
    logic               busy;
    logic               confirmed;
    logic               failed;
    logic [1:0]         done_id;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    delivery_dispatch_ctrl #(
        .NUM_REQ   (NUM_REQ),
        .WAIT_LIMIT(WAIT_LIMIT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .customs_cleared   (customs),
        .transit_ready     (transit),
        .arrived_on_truck  (arrived),
        .grant             (grant),
        .grant_id          (grant_id),
        .busy              (busy),
        .delivery_confirmed(confirmed),
        .delivery_failed   (failed),
        .done_id           (done_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Shipment-level model: gates_passed counts how many of customs / loading /
    // arrival the current shipment has cleared; outcome 1 = delivered, 2 = aborted.
    typedef struct {
        bit active;
        int owner;
        int last;
        int gates_passed;
        int outcome;
        int waited;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.active = 0; r.owner = 0; r.last = NUM_REQ - 1;
        r.gates_passed = 0; r.outcome = 0; r.waited = 0;
        return r;
    endfunction

    function automatic model_t model_next(input model_t cur, input logic [NUM_REQ-1:0] r,
                                          input logic c, input logic t, input logic a);
        model_t nx = cur;
        bit gate_open;
        if (!cur.active) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int cand = (cur.last + k) % NUM_REQ;
                if (!nx.active && r[cand]) begin
                    nx.active = 1; nx.owner = cand; nx.last = cand;
                    nx.gates_passed = 0; nx.outcome = 0; nx.waited = 0;
                end
            end
        end else if (cur.outcome != 0) begin
            nx.active = 0; nx.outcome = 0; nx.gates_passed = 0; nx.waited = 0;
        end else begin
            case (cur.gates_passed)
                0:       gate_open = c;
                1:       gate_open = c && t;
                default: gate_open = a;
            endcase
            if (!r[cur.owner]) begin
                nx.outcome = 2; nx.waited = 0;
            end else if (gate_open) begin
                nx.waited = 0;
                if (cur.gates_passed < 2) nx.gates_passed = cur.gates_passed + 1;
                else nx.outcome = (c && t) ? 1 : 2;
            end else if (TIMEOUT_ON && cur.waited == WAIT_LIMIT) begin
                nx.outcome = 2; nx.waited = 0;
            end else begin
                nx.waited = (cur.waited < WAIT_LIMIT) ? cur.waited + 1 : WAIT_LIMIT;
            end
        end
        return nx;
    endfunction

    always @(posedge clk) begin
        m <= rst ? model_reset() : model_next(m, req, customs, transit, arrived);
        started <= 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("model_busy",      32'(busy),      32'(m.active));
            check("model_grant",     32'(grant),     m.active ? (32'h1 << m.owner) : 32'h0);
            check("model_grant_id",  32'(grant_id),  m.active ? 32'(m.owner) : 32'h0);
            check("model_confirmed", 32'(confirmed), 32'(m.active && m.outcome == 1));
            check("model_failed",    32'(failed),    32'(m.active && m.outcome == 2));
            check("pulse_exclusive", 32'(confirmed & failed), 32'h0);
            if (m.active && m.outcome != 0)
                check("model_done_id", 32'(done_id), 32'(m.owner));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int waited_cycles;
        bit saw_pulse;

        // Reset values
        tick(); tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_pulses", 32'({confirmed, failed}), 32'h0);
        check("rst_done_id", 32'(done_id), 32'h0);
        rst = 1'b0;

        // Single requester, status raised one per cycle
        req = 4'b0001;
        tick(); check("t1_grant", 32'(grant), 32'h1);
        customs = 1'b1; tick();
        transit = 1'b1; tick();
        arrived = 1'b1; tick();
        check("t1_confirmed", 32'(confirmed), 32'h1);
        check("t1_done_id", 32'(done_id), 32'h0);
        req = '0; tick();
        check("t1_grant_cleared", 32'(grant), 32'h0);
        check("t1_idle", 32'(busy), 32'h0);

        // All requesting, all status high: round robin from requester 0
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_grant_id", 32'(grant_id), 32'(exp_order[k]));
            check("t2_grant", 32'(grant), 32'h1 << exp_order[k]);
            tick(); tick(); tick();
            check("t2_confirmed", 32'(confirmed), 32'h1);
            check("t2_done_id", 32'(done_id), 32'(exp_order[k]));
            tick();
            check("t2_idle", 32'(busy), 32'h0);
            if (k == 4) req = '0;
        end
        customs = 1'b0; transit = 1'b0; arrived = 1'b0;

        // Owner 2 reaches transit, transit_ready drops before arrival
        req = 4'b0100; customs = 1'b1; transit = 1'b1;
        tick(); check("t3_grant", 32'(grant), 32'h4);
        tick(); tick();
        transit = 1'b0; tick();
        check("t3_still_waiting", 32'({busy, failed}), 32'h2);
        arrived = 1'b1; tick();
        check("t3_failed", 32'(failed), 32'h1);
        check("t3_done_id", 32'(done_id), 32'h2);
        check("t3_grant_held", 32'(grant), 32'h4);
        req = '0; customs = 1'b0; arrived = 1'b0; tick();
        check("t3_idle", 32'(busy), 32'h0);

        // Owner 3 drops its request in LOAD; requester 1 follows
        req = 4'b1010; customs = 1'b1;
        tick(); check("t4_grant_id", 32'(grant_id), 32'h3);
        tick();
        req = 4'b0010; tick();
        check("t4_failed", 32'(failed), 32'h1);
        check("t4_done_id", 32'(done_id), 32'h3);
        tick(); check("t4_idle", 32'(busy), 32'h0);
        tick(); check("t4_next_grant", 32'(grant), 32'h2);
        transit = 1'b1; arrived = 1'b1;
        tick(); tick(); tick();
        check("t4_confirmed", 32'(confirmed), 32'h1);
        check("t4_confirm_id", 32'(done_id), 32'h1);
        req = '0; customs = 1'b0; transit = 1'b0; arrived = 1'b0; tick();

        // Stuck in CUSTOMS
        req = 4'b0001;
        tick(); check("t5_grant", 32'(grant), 32'h1);
        if (TIMEOUT_ON) begin
            waited_cycles = 0;
            saw_pulse = 1'b0;
            while (!saw_pulse && waited_cycles < 40) begin
                tick();
                waited_cycles++;
                saw_pulse = failed;
            end
            check("t5_timeout_latency", 32'(waited_cycles), 32'd16);
            check("t5_timeout_id", 32'(done_id), 32'h0);
            req = '0; tick();
        end else begin
            saw_pulse = 1'b0;
            for (int k = 0; k < 100; k++) begin
                tick();
                if (confirmed || failed) saw_pulse = 1'b1;
            end
            check("t5_no_pulse", 32'(saw_pulse), 32'h0);
            check("t5_still_busy", 32'(busy), 32'h1);
            req = '0; tick();
            check("t5_abort", 32'(failed), 32'h1);
            tick();
        end
        check("t5_idle", 32'(busy), 32'h0);

        // Reset while in TRANSIT
        req = 4'b0100; customs = 1'b1; transit = 1'b1;
        tick(); check("t6_grant", 32'(grant), 32'h4);
        tick(); tick();
        check("t6_in_transit", 32'(busy), 32'h1);
        rst = 1'b1; tick();
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_grant", 32'(grant), 32'h0);
        check("t6_rst_pulses", 32'({confirmed, failed}), 32'h0);
        rst = 1'b0; req = 4'b0101; arrived = 1'b1;
        tick(); check("t6_regrant", 32'(grant), 32'h1);
        tick(); tick(); tick();
        check("t6_confirmed", 32'(confirmed), 32'h1);
        check("t6_done_id", 32'(done_id), 32'h0);
        req = '0; customs = 1'b0; transit = 1'b0; arrived = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
